// File: rtl/board_painter.sv
// Paints the 4x4 tile board into the frame buffer once per start pulse, one
// pixel per accepted write, raster order over the 4*CELL square region.
module board_painter #(
  parameter int          X0           = 120,
  parameter int          Y0           = 40,
  parameter int          CELL         = 100,
  parameter int          BORDER       = 4,
  parameter logic [11:0] BORDER_COLOR = 12'hBBA
) (
  input  logic        dclk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [63:0] board,
  output logic        busy,
  output logic        done,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic [1:0]  state
);

  localparam int LW = $clog2(CELL);
  localparam logic [LW-1:0] LAST_L    = LW'(CELL - 1);
  localparam logic [LW-1:0] B_LO      = LW'(BORDER);
  localparam logic [LW-1:0] B_HI      = LW'(CELL - BORDER);
  localparam logic [18:0]   BASE      = 19'(Y0 * 640 + X0);
  localparam logic [18:0]   LINE_SKIP = 19'(640 - (4 * CELL - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, PAINT = 2'd1, DONE = 2'd2} state_t;

  state_t        st;
  logic [63:0]   board_q;
  logic [1:0]    col, row;
  logic [LW-1:0] lx, ly;

  logic [1:0]    n_col, n_row;
  logic [LW-1:0] n_lx, n_ly;
  logic [63:0]   n_board;
  logic [3:0]    n_exp;
  logic [11:0]   n_color;
  logic          line_end, frame_end;

  function automatic logic [11:0] palette(input logic [3:0] e);
    case (e)
      4'd0:    return 12'hCCB;
      4'd1:    return 12'hEED;
      4'd2:    return 12'hEEC;
      4'd3:    return 12'hFB7;
      4'd4:    return 12'hF96;
      4'd5:    return 12'hF76;
      4'd6:    return 12'hF53;
      4'd7:    return 12'hEC7;
      4'd8:    return 12'hEC6;
      4'd9:    return 12'hEC5;
      4'd10:   return 12'hEC3;
      default: return 12'hEC2;
    endcase
  endfunction

  // Next-pixel counters and colour are computed here so the outputs can be
  // registered together with the counters on each handshake.
  always_comb begin
    line_end  = (col == 2'd3) && (lx == LAST_L);
    frame_end = line_end && (row == 2'd3) && (ly == LAST_L);
    n_col   = col;
    n_row   = row;
    n_lx    = lx;
    n_ly    = ly;
    n_board = board_q;
    if (st == IDLE) begin
      n_col   = '0;
      n_row   = '0;
      n_lx    = '0;
      n_ly    = '0;
      n_board = board;
    end else begin
      if (lx == LAST_L) begin
        n_lx  = '0;
        n_col = col + 2'd1;
      end else begin
        n_lx = lx + 1'b1;
      end
      if (line_end) begin
        if (ly == LAST_L) begin
          n_ly  = '0;
          n_row = row + 2'd1;
        end else begin
          n_ly = ly + 1'b1;
        end
      end
    end
    n_exp = n_board[{n_row, n_col, 2'b00} +: 4];
    if (n_lx < B_LO || n_lx >= B_HI || n_ly < B_LO || n_ly >= B_HI) begin
      n_color = BORDER_COLOR;
    end else begin
      n_color = palette(n_exp);
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      st       <= IDLE;
      board_q  <= '0;
      col      <= '0;
      row      <= '0;
      lx       <= '0;
      ly       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            board_q  <= board;
            col      <= n_col;
            row      <= n_row;
            lx       <= n_lx;
            ly       <= n_ly;
            wr_addr  <= BASE;
            wr_data  <= n_color;
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            st       <= PAINT;
          end
        end
        PAINT: begin
          if (wr_ready) begin
            if (frame_end) begin
              wr_valid <= 1'b0;
              done     <= 1'b1;
              st       <= DONE;
            end else begin
              col     <= n_col;
              row     <= n_row;
              lx      <= n_lx;
              ly      <= n_ly;
              wr_addr <= line_end ? wr_addr + LINE_SKIP : wr_addr + 19'd1;
              wr_data <= n_color;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: doc/board_painter.md
# board_painter

Fills the 2048 game board region of the pixel frame buffer from a 4x4 array of tile exponents. It sits directly upstream of the 640x480 VGA scan-out stage and writes 12-bit RGB pixels through a valid/ready write port. On a `start` pulse it latches the board, walks the 400x400 board region once in raster order, then pulses `done`.

## Interface
Parameters:
- `X0`, 120: left edge of the board region, in pixels.
- `Y0`, 40: top edge of the board region, in lines.
- `CELL`, 100: cell pitch in pixels; the board is 4*CELL square.
- `BORDER`, 4: border width inside each cell, in pixels.
- `BORDER_COLOR`, 12'hBBA: RGB value for border pixels.

Ports:
- `dclk` input 1: pixel clock; all logic is on the rising edge.
- `clr_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a repaint; sampled only in IDLE.
- `board` input 64: tile i = `board[4i+3:4i]`, where i = row*4+col and row 0 is the top row.
- `busy` output 1: high in PAINT and DONE.
- `done` output 1: one-cycle pulse when a repaint completes.
- `wr_valid` output 1: a pixel write is presented.
- `wr_ready` input 1: the frame buffer accepts the write this cycle.
- `wr_addr` output 19: pixel address, = y*640 + x in absolute screen coordinates.
- `wr_data` output 12: [11:8] red, [7:4] green, [3:0] blue.

## Operation
- FSM states: IDLE, PAINT, DONE.
- IDLE + `start`=1:
  - latch `board` into an internal register;
  - clear the relative counters: x=0, y=0, cell col/row = 0, local lx/ly = 0;
  - load the address register with Y0*640+X0;
  - go to PAINT.
- PAINT:
  - `wr_valid`=1.
  - Outputs are registered and present pixel (x,y) until the handshake `wr_valid && wr_ready`.
  - On a handshake, advance x. When x=399 wraps to 0, increment y, and the address advances by 640-399 instead of by 1.
  - Local offsets lx/ly count 0..CELL-1 and carry into cell col/row. The RTL must use no dividers or multipliers on counters; the only constant multiplication is for the address reload.
- DONE: `done`=1 and `busy`=1 for one cycle, then return to IDLE.
- Pixel colour:
  - Border if lx<BORDER, lx>=CELL-BORDER, ly<BORDER or ly>=CELL-BORDER; the pixel gets BORDER_COLOR.
  - Otherwise the pixel gets palette[e], with e the latched exponent of tile (row,col).
- Palette:
  - 0:CCB, 1:EED, 2:EEC, 3:FB7, 4:F96, 5:F76;
  - 6:F53, 7:EC7, 8:EC6, 9:EC5, 10:EC3;
  - 11..15:EC2 (saturates).
- Boundaries:
  - `start` in PAINT or DONE is ignored; it is not queued.
  - `board` changes after the start cycle have no effect until the next start.
  - While stalled (`wr_valid`=1, `wr_ready`=0), `wr_addr` and `wr_data` hold stable.
  - `wr_ready` is ignored when `wr_valid`=0.
  - The last pixel (399,399) sits at address 439*640+519 = 281479. Its handshake moves PAINT to DONE; no further write is issued.
  - `clr_n` low at any time: asynchronous return to IDLE; no `done` pulse; the partial image stays in the frame buffer.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, state IDLE.
- Start sampled at edge 0: `busy` and `wr_valid` go high after edge 0, presenting the pixel at address 25720.
- With `wr_ready` held at 1: one pixel per cycle; exactly 160000 handshakes. The last handshake is at edge 160000 and `done` is high for the cycle after it.
- Under backpressure, latency = 160000 + number of stall cycles + 1.
- Back-to-back: a `start` presented in the cycle after DONE (state IDLE) is accepted.

## Test plan
- Reset: hold `clr_n`=0 and toggle `dclk` -> all outputs 0; releasing reset with `start`=0 -> `wr_valid` stays 0.
- `board`=0, `wr_ready`=1, `start` pulse:
  - first write addr 25720, data BBA;
  - pixel (4,4): addr 28284, data CCB;
  - last write addr 281479;
  - exactly 160000 writes; `done` one cycle after the last write.
- `board`=64'h0000_0000_00B0_0000 (tile 5 = 11): addr 121870 (x=150, y=150) -> data EC2. Repeat with tile 5 = 15 -> EC2; tile 5 = 3 -> FB7.
- Random `wr_ready` (about 50% duty):
  - addr/data stable during stalls;
  - accepted sequence identical to the full-rate run;
  - `done` only after 160000 handshakes.
- `start` re-pulsed and `board` changed mid-paint -> no restart; colours follow the originally latched board; a single `done`.
- `clr_n` pulsed low at pixel 5000:
  - outputs 0 immediately;
  - no `done`;
  - a new `start` restarts at addr 25720.
